// File: rtl/sum_accumulator.sv
// Sums COUNT unsigned beats (or a shorter flushed block) and holds the block total,
// beat count and sticky overflow on a valid/ready output until it is accepted.
module sum_accumulator #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned COUNT     = 4,
    parameter int unsigned ACC_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [7:0]           out_cnt,
    output logic                 out_ovf
);

    localparam int unsigned AddWidth = ACC_WIDTH + 1;

    typedef enum logic {StAccum, StHold} state_e;

    state_e                 r_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [7:0]             r_cnt;
    logic                   r_ovf;
    logic [ACC_WIDTH-1:0]   r_out_sum;
    logic [7:0]             r_out_cnt;
    logic                   r_out_ovf;

    logic                   w_beat;
    logic [AddWidth-1:0]    w_add;
    logic [ACC_WIDTH-1:0]   w_acc_nxt;
    logic                   w_ovf_nxt;
    logic [7:0]             w_cnt_nxt;
    logic                   w_close;

    // Handshake signals depend on the state register only, so out_ready never reaches in_ready.
    assign in_ready  = (r_state == StAccum);
    assign out_valid = (r_state == StHold);
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;

    assign w_beat    = in_valid & in_ready;
    assign w_add     = {1'b0, r_acc} + AddWidth'(in_data);
    assign w_acc_nxt = w_beat ? w_add[ACC_WIDTH-1:0] : r_acc;
    assign w_ovf_nxt = r_ovf | (w_beat & w_add[ACC_WIDTH]);
    assign w_cnt_nxt = r_cnt + {7'd0, w_beat};
    // A flush closes the block only when it holds at least one beat, including this cycle's.
    assign w_close   = (w_beat && (w_cnt_nxt == 8'(COUNT))) || (flush && (w_cnt_nxt != 8'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StAccum;
            r_acc     <= '0;
            r_cnt     <= 8'd0;
            r_ovf     <= 1'b0;
            r_out_sum <= '0;
            r_out_cnt <= 8'd0;
            r_out_ovf <= 1'b0;
        end else begin
            unique case (r_state)
                StAccum: begin
                    if (w_close) begin
                        r_out_sum <= w_acc_nxt;
                        r_out_cnt <= w_cnt_nxt;
                        r_out_ovf <= w_ovf_nxt;
                        r_acc     <= '0;
                        r_cnt     <= 8'd0;
                        r_ovf     <= 1'b0;
                        r_state   <= StHold;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= w_ovf_nxt;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        r_state <= StAccum;
                    end
                end
                default: r_state <= StAccum;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomised scoreboard bench for sum_accumulator: a block-level model predicts each
// result and a separate monitor compares whatever the DUT presents on its output.
module tb_sum_accumulator;

    localparam int WIDTH = 8;
    localparam int COUNT = 4;
    localparam int AW    = 9;

    typedef struct {
        int unsigned sum;
        int unsigned cnt;
        bit          ovf;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WIDTH-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [7:0]    out_cnt;
    logic          out_ovf;

    exp_t          expq[$];
    int unsigned   blk[$];
    bit            m_hold;
    int            total;
    int            bad;

    sum_accumulator #(
        .WIDTH     (WIDTH),
        .COUNT     (COUNT),
        .ACC_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Block-level model: a block is a list of beats; its result is plain integer arithmetic.
    function automatic void model_step();
        int unsigned t;
        exp_t        e;
        if (!m_hold) begin
            if (in_valid) blk.push_back(int'(in_data));
            if ((in_valid && blk.size() == COUNT) || (flush && blk.size() != 0)) begin
                t = 0;
                foreach (blk[i]) t += blk[i];
                e.sum = t % (1 << AW);
                e.cnt = blk.size();
                e.ovf = (t >= (1 << AW));
                expq.push_back(e);
                blk.delete();
                m_hold = 1'b1;
            end
        end else if (out_ready) begin
            m_hold = 1'b0;
        end
    endfunction

    // Called one time unit after a rising edge; returns one time unit after the next one.
    task automatic step(input bit v, input int d, input bit f, input bit r);
        in_valid  = v;
        in_data   = d[WIDTH-1:0];
        flush     = f;
        out_ready = r;
        @(posedge clk);
        model_step();
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, !m_hold});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
    endtask

    task automatic async_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {23'd0, out_sum}, 32'd0);
        blk.delete();
        expq.delete();
        m_hold = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the presented result against the queue head, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (expq.size() == 0) begin
                    check("out_valid_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("out_sum", {23'd0, out_sum}, expq[0].sum);
                    check("out_cnt", {24'd0, out_cnt}, expq[0].cnt);
                    check("out_ovf", {31'd0, out_ovf}, {31'd0, expq[0].ovf});
                    if (out_ready) void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        m_hold    = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_sum", {23'd0, out_sum}, 32'd0);
        check("reset_out_cnt", {24'd0, out_cnt}, 32'd0);
        check("reset_out_ovf", {31'd0, out_ovf}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Empty flush, then a flushed partial block.
        step(0, 0, 1, 1);
        step(1, 5, 0, 1);
        step(1, 7, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        // Beat coincident with flush is part of the block.
        step(1, 1, 0, 1);
        step(1, 2, 0, 1);
        step(1, 9, 1, 1);
        step(0, 0, 0, 1);
        // Full block with overflow, stalled output, offered beats must be ignored.
        for (int i = 0; i < 4; i++) step(1, 255, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 3, 0, 0);
        step(0, 0, 0, 1);
        // Sticky overflow clears per block.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
        step(0, 0, 0, 1);

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // Asynchronous reset mid-block discards the partial sum.
        step(1, 100, 0, 1);
        step(1, 100, 0, 1);
        async_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // Asynchronous reset while a result is pending.
        for (int i = 0; i < 4; i++) step(1, 50, 0, 0);
        step(0, 0, 0, 0);
        async_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        check("queue_drained", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
